// File: rtl/demux_frame_arbiter.sv
// demux_frame_arbiter
//
// Round-robin arbiter and sequencer for one serial source shared by two sinks
// through a 1-bit demultiplexer. A sink asks for a whole frame with req[i].
// The block grants one sink, drives the demux select and paces FRAME_LEN beats
// with a valid/ready handshake. It then pulses frame_done for that sink and
// goes back to arbitration. No data passes through this block. It only steers
// the demux and qualifies the handshake signals.
//
// Parameters
//   FRAME_LEN  beats per frame (1..255)
//   CNT_W      beat counter width, 2**CNT_W > FRAME_LEN
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req[1:0]    per-sink frame request, sampled only while idle
//   src_valid   source presents a bit this cycle
//   src_ready   source bit is accepted this cycle (combinational)
//   dst_ready   per-sink ready; only the selected sink's bit matters
//   sel         demux select (0 -> sink 0, 1 -> sink 1), registered
//   dst_valid   per-sink bit-valid strobe; only the selected sink can be high
//   frame_done  one-cycle completion pulse for the sink that was served
//   busy        high whenever a frame is granted, running or completing
module demux_frame_arbiter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic [1:0] dst_ready,
  output logic       sel,
  output logic [1:0] dst_valid,
  output logic [1:0] frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sel_reg;
  logic             rr_last_reg;
  logic             busy_reg;
  logic [1:0]       done_reg;

  logic in_xfer;
  logic beat;
  logic winner;

  assign in_xfer = (state_reg == XFER);
  // A beat needs both sides. The other sink's ready is ignored.
  assign beat    = in_xfer && src_valid && dst_ready[sel_reg];

  // On a tie, the sink that was not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~rr_last_reg;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sel_reg     <= 1'b0;
      // Start with rr_last at 1 so that sink 0 wins the first tie.
      rr_last_reg <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 2'b00;
    end else begin
      done_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            state_reg <= GRANT;
            sel_reg   <= winner;
            busy_reg  <= 1'b1;
          end
        end
        GRANT: begin
          state_reg <= XFER;
          cnt_reg   <= '0;
        end
        XFER: begin
          if (beat) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_BEAT) begin
              state_reg <= DONE;
              // Registered here so the pulse lands in the DONE cycle.
              done_reg  <= sel_reg ? 2'b10 : 2'b01;
            end
          end
        end
        DONE: begin
          state_reg   <= IDLE;
          rr_last_reg <= sel_reg;
          busy_reg    <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign src_ready  = in_xfer && dst_ready[sel_reg];
  assign sel        = sel_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

  // The bit-valid strobe goes only to the selected sink.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dst_valid
      assign dst_valid[gi] = in_xfer && (sel_reg == 1'(gi)) && src_valid;
    end
  endgenerate

endmodule

// File: tb/tb_demux_frame_arbiter.sv
module tb_demux_frame_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       src_valid;
  logic [1:0] dst_ready;

  logic       src_ready, sel, busy;
  logic [1:0] dst_valid, frame_done;
  logic       src_ready1, sel1, busy1;
  logic [1:0] dst_valid1, frame_done1;

  always #5 clk = ~clk;

  demux_frame_arbiter #(.FRAME_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_valid(src_valid),
    .src_ready(src_ready), .dst_ready(dst_ready), .sel(sel),
    .dst_valid(dst_valid), .frame_done(frame_done), .busy(busy)
  );

  demux_frame_arbiter #(.FRAME_LEN(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .src_valid(src_valid),
    .src_ready(src_ready1), .dst_ready(dst_ready), .sel(sel1),
    .dst_valid(dst_valid1), .frame_done(frame_done1), .busy(busy1)
  );

  // Observed output vector: {sel, busy, src_ready, dst_valid[1:0], frame_done[1:0]}
  wire [6:0] obs8 = {sel, busy, src_ready, dst_valid, frame_done};
  wire [6:0] obs1 = {sel1, busy1, src_ready1, dst_valid1, frame_done1};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model at frame level: who owns the source, how many cycles
  // have passed since the grant, and how many beats have been delivered.
  int m_owner;  // -1 when no frame is active
  int m_age;
  int m_beats;
  int m_last;
  int m_sel;

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_beats = 0; m_last = 1; m_sel = 0;
  endtask

  // Returns the outputs expected in the current cycle for the current
  // inputs, then moves the model across the next rising edge.
  task automatic model_step(input int fl, output logic [6:0] e);
    logic       moving, finished;
    logic [1:0] dv, fd;
    int         w;
    moving   = (m_owner >= 0) && (m_age >= 1) && (m_beats < fl);
    finished = (m_owner >= 0) && (m_beats == fl);
    dv = (moving && src_valid) ? (2'b01 << m_sel) : 2'b00;
    fd = finished ? (2'b01 << m_owner) : 2'b00;
    e  = {m_sel[0], (m_owner >= 0), (moving && dst_ready[m_sel]), dv, fd};
    if (m_owner < 0) begin
      if (req != 2'b00) begin
        w = (req == 2'b11) ? (1 - m_last) : ((req == 2'b10) ? 1 : 0);
        m_owner = w; m_sel = w; m_age = 0; m_beats = 0;
      end
    end else if (finished) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      if (moving && src_valid && dst_ready[m_sel]) m_beats++;
      m_age++;
    end
  endtask

  task automatic drive_cycle(input logic [1:0] r, input logic sv, input logic [1:0] dr);
    @(negedge clk);
    req = r; src_valid = sv; dst_ready = dr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 2'b00; src_valid = 1'b0; dst_ready = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [6:0] e;
    @(negedge clk);
    rst_n = 1'b0; req = 2'b11; src_valid = 1'b1; dst_ready = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    e = 7'b0;
    n_checks++;
    if (obs8 !== e) $display("FAIL reset_outputs_len8: got %b expected %b", obs8, e);
    else n_pass++;
    n_checks++;
    if (obs1 !== e) $display("FAIL reset_outputs_len1: got %b expected %b", obs1, e);
    else n_pass++;
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("test_reset: outputs %b / %b while held in reset", obs8, obs1);
  endtask

  task automatic test_single_frame();
    logic [6:0] e;
    int first_dv = -1, last_dv = -1, n_dv = 0, done_at = -1, idle_at = -1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive_cycle((i == 0) ? 2'b01 : 2'b00, 1'b1, 2'b11);
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL single_frame cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
      if (dst_valid == 2'b01) begin
        if (first_dv < 0) first_dv = i;
        last_dv = i; n_dv++;
      end
      if (frame_done == 2'b01 && done_at < 0) done_at = i;
      if (done_at >= 0 && i > done_at && !busy && idle_at < 0) idle_at = i;
    end
    n_checks++;
    if (first_dv != 2 || last_dv != 9 || n_dv != 8)
      $display("FAIL single_frame_window: got first=%0d last=%0d count=%0d expected 2/9/8", first_dv, last_dv, n_dv);
    else n_pass++;
    n_checks++;
    if (done_at != 10 || idle_at != 11)
      $display("FAIL single_frame_done: got done=%0d idle=%0d expected 10/11", done_at, idle_at);
    else n_pass++;
    $display("test_single_frame: beats %0d in cycles %0d..%0d, done at %0d", n_dv, first_dv, last_dv, done_at);
  endtask

  task automatic test_round_robin();
    logic [6:0] e;
    logic       prev_busy = 1'b0;
    int         gcyc[$];
    logic       gsel[$];
    logic [1:0] dq[$];
    do_reset();
    for (int i = 0; i < 48; i++) begin
      drive_cycle(2'b11, 1'b1, 2'b11);
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL round_robin cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
      if (busy && !prev_busy) begin gcyc.push_back(i); gsel.push_back(sel); end
      if (frame_done != 2'b00) dq.push_back(frame_done);
      prev_busy = busy;
    end
    n_checks++;
    if (gcyc.size() < 4 || dq.size() < 4)
      $display("FAIL round_robin_count: got grants=%0d dones=%0d expected at least 4/4", gcyc.size(), dq.size());
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (gsel[k] !== 1'(k % 2) || dq[k] !== ((k % 2) ? 2'b10 : 2'b01))
          $display("FAIL round_robin_grant %0d: got sel=%b done=%b expected sel=%0d", k, gsel[k], dq[k], k % 2);
        else n_pass++;
        if (k > 0) begin
          n_checks++;
          if (gcyc[k] - gcyc[k-1] != 11)
            $display("FAIL round_robin_period %0d: got %0d expected 11", k, gcyc[k] - gcyc[k-1]);
          else n_pass++;
        end
      end
      $display("test_round_robin: grants at %0d,%0d,%0d,%0d", gcyc[0], gcyc[1], gcyc[2], gcyc[3]);
    end
  endtask

  task automatic test_stall();
    logic [6:0] e;
    logic [1:0] dr;
    int beats = 0, stall = 0, done_at = -1, ready_in_stall = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      dr = (beats >= 4 && stall < 3) ? 2'b10 : 2'b11;
      drive_cycle((i == 0) ? 2'b01 : 2'b00, 1'b1, dr);
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL stall cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
      if (dr == 2'b10) begin
        stall++;
        if (src_ready) ready_in_stall++;
      end
      if (src_ready && dst_valid[0]) beats++;
      if (frame_done == 2'b01 && done_at < 0) done_at = i;
    end
    n_checks++;
    if (beats != 8 || done_at != 13 || ready_in_stall != 0)
      $display("FAIL stall_summary: got beats=%0d done=%0d ready_in_stall=%0d expected 8/13/0", beats, done_at, ready_in_stall);
    else n_pass++;
    $display("test_stall: %0d beats, done at cycle %0d", beats, done_at);
  endtask

  task automatic test_req_drop();
    logic [6:0] e;
    int beats = 0, done_at = -1, busy_after = 0;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive_cycle((i < 3) ? 2'b10 : 2'b00, 1'b1, 2'b11);
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL req_drop cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
      if (dst_valid == 2'b10 && src_ready) beats++;
      if (frame_done == 2'b10 && done_at < 0) done_at = i;
      if (i >= 11 && busy) busy_after++;
    end
    n_checks++;
    if (beats != 8 || done_at != 10 || busy_after != 0)
      $display("FAIL req_drop_summary: got beats=%0d done=%0d busy_after=%0d expected 8/10/0", beats, done_at, busy_after);
    else n_pass++;
    $display("test_req_drop: %0d beats, done at cycle %0d", beats, done_at);
  endtask

  task automatic test_async_reset();
    logic [6:0] e;
    int done_seen = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_cycle((i == 0) ? 2'b10 : 2'b00, 1'b1, 2'b11);
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL async_reset_pre cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
    end
    // Fifth beat is in progress; drop reset between clock edges.
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs8 !== 7'b0) $display("FAIL async_reset_immediate: got %b expected %b", obs8, 7'b0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b00, 1'b0, 2'b00);
      if (frame_done != 2'b00) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL async_reset_no_done: got %0d pulses expected 0", done_seen);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(2'b11, 1'b1, 2'b11);
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL async_reset_post cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (busy !== 1'b1 || sel !== 1'b0)
          $display("FAIL async_reset_first_tie: got busy=%b sel=%b expected 1/0", busy, sel);
        else n_pass++;
      end
    end
    $display("test_async_reset: frame aborted, next tie granted sel=%b", sel);
  endtask

  task automatic test_len1_random();
    logic [6:0] e;
    logic       prev_busy = 1'b0;
    int dv_in_frame = 0, frames = 0, bad = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'b11);
      model_step(1, e);
      n_checks++;
      if (obs1 !== e) $display("FAIL len1 cycle %0d: got %b expected %b", i, obs1, e);
      else n_pass++;
      if (busy1 && !prev_busy) dv_in_frame = 0;
      if (dst_valid1 != 2'b00) begin
        dv_in_frame++;
        if (dst_valid1 != (2'b01 << sel1)) bad++;
      end
      if (frame_done1 != 2'b00) begin
        frames++;
        n_checks++;
        if (dv_in_frame != 1) $display("FAIL len1_beats frame %0d: got %0d expected 1", frames, dv_in_frame);
        else n_pass++;
      end
      prev_busy = busy1;
    end
    n_checks++;
    if (bad != 0 || frames == 0)
      $display("FAIL len1_sel_agree: got %0d disagreements over %0d frames expected 0 over >0", bad, frames);
    else n_pass++;
    $display("test_len1_random: %0d frames", frames);
  endtask

  task automatic test_random_len8();
    logic [6:0] e;
    int frames = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      model_step(8, e);
      n_checks++;
      if (obs8 !== e) $display("FAIL random8 cycle %0d: got %b expected %b", i, obs8, e);
      else n_pass++;
      if (frame_done != 2'b00) frames++;
    end
    $display("test_random_len8: %0d frames completed", frames);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; src_valid = 1'b0; dst_ready = 2'b00;
    model_reset();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
    test_req_drop();
    test_async_reset();
    test_len1_random();
    test_random_len8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
